// File: rtl/sa_feeder.sv
// sa_feeder: turns a stream of 3-row matrix columns into diagonally skewed
// lane data for a 3-lane systolic array. Lane i sees the column element from
// row i delayed by i cycles, so one column lands on the array as a diagonal.
// A small IDLE/STREAM/DRAIN controller frames the input stream, stalls the
// source while the tail of a frame drains out of lane 3, and flags frames
// cut off at MAX_BEATS.
module sa_feeder #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] col_1,
    input  logic [DATA_W-1:0] col_2,
    input  logic [DATA_W-1:0] col_3,
    output logic [DATA_W-1:0] subject_in_1,
    output logic [DATA_W-1:0] subject_in_2,
    output logic [DATA_W-1:0] subject_in_3,
    output logic              sa_en,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Count value held just before accepting beat number MAX_BEATS.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    state_t state, state_nxt;
    logic [7:0] beat_cnt, beat_cnt_nxt;
    logic       drain_cnt, drain_cnt_nxt;
    logic       err_nxt;
    logic       frame_done_nxt;

    logic              accept;
    logic [DATA_W-1:0] x_1, x_2, x_3;

    // Skew registers: lane 1 one stage, lane 2 two stages, lane 3 three.
    logic [DATA_W-1:0] lane1_q0;
    logic [DATA_W-1:0] lane2_q0, lane2_q1;
    logic [DATA_W-1:0] lane3_q0, lane3_q1, lane3_q2;
    logic              val1_q0;
    logic              val2_q0, val2_q1;
    logic              val3_q0, val3_q1, val3_q2;

    // The source is held off while the frame tail drains, and while in reset.
    assign in_ready = reset && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // Non-accepted cycles feed zero bubbles so the diagonal stays aligned.
    assign x_1 = accept ? col_1 : '0;
    assign x_2 = accept ? col_2 : '0;
    assign x_3 = accept ? col_3 : '0;

    assign subject_in_1 = lane1_q0;
    assign subject_in_2 = lane2_q1;
    assign subject_in_3 = lane3_q2;
    assign sa_en        = val1_q0 | val2_q1 | val3_q2;

    // Controller state, counters and the registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            drain_cnt  <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the statement order.
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            drain_cnt  <= drain_cnt_nxt;
            err        <= err_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state logic: frame on in_last or truncate at MAX_BEATS, then drain.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nxt      = state;
        beat_cnt_nxt   = beat_cnt;
        drain_cnt_nxt  = drain_cnt;
        err_nxt        = err;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                    if (in_last || (beat_cnt == LAST_BEAT)) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = 1'b1;
                        // Hitting the beat limit without in_last is a truncation.
                        if (!in_last) begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == 1'b0) begin
                    state_nxt      = IDLE;
                    beat_cnt_nxt   = '0;
                    frame_done_nxt = 1'b1;
                end else begin
                    drain_cnt_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Skew pipeline and its valid bits; shifts every cycle, accepted or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the skew registers are reset (not left free-running like a
            // RAM) because reset must discard in-flight data and zero the lanes.
            lane1_q0 <= '0;
            lane2_q0 <= '0;
            lane2_q1 <= '0;
            lane3_q0 <= '0;
            lane3_q1 <= '0;
            lane3_q2 <= '0;
            val1_q0  <= 1'b0;
            val2_q0  <= 1'b0;
            val2_q1  <= 1'b0;
            val3_q0  <= 1'b0;
            val3_q1  <= 1'b0;
            val3_q2  <= 1'b0;
        end else begin
            lane1_q0 <= x_1;
            lane2_q0 <= x_2;
            lane2_q1 <= lane2_q0;
            lane3_q0 <= x_3;
            lane3_q1 <= lane3_q0;
            lane3_q2 <= lane3_q1;
            val1_q0  <= accept;
            val2_q0  <= accept;
            val2_q1  <= val2_q0;
            val3_q0  <= accept;
            val3_q1  <= val3_q0;
            val3_q2  <= val3_q1;
        end
    end

endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: drives two feeders (MAX_BEATS 16 and 4) from one shared
// source. A behavioural model records, per clock edge, which column each
// instance accepted; expected lane i output after edge n is the column element
// accepted at edge n-(i-1). Frame bookkeeping (beats, end edge, error) gives
// in_ready, busy, frame_done and err.
module tb_sa_feeder;

    localparam int NCYC = 4096;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_last;
    logic [7:0] col_1, col_2, col_3;

    logic       rdy [2];
    logic [7:0] s1  [2];
    logic [7:0] s2  [2];
    logic [7:0] s3  [2];
    logic       en  [2];
    logic       fd  [2];
    logic       bsy [2];
    logic       er  [2];

    sa_feeder #(.DATA_W(8), .MAX_BEATS(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_last(in_last), .col_1(col_1), .col_2(col_2), .col_3(col_3),
        .subject_in_1(s1[0]), .subject_in_2(s2[0]), .subject_in_3(s3[0]),
        .sa_en(en[0]), .frame_done(fd[0]), .busy(bsy[0]), .err(er[0])
    );

    sa_feeder #(.DATA_W(8), .MAX_BEATS(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_last(in_last), .col_1(col_1), .col_2(col_2), .col_3(col_3),
        .subject_in_1(s1[1]), .subject_in_2(s2[1]), .subject_in_3(s3[1]),
        .sa_en(en[1]), .frame_done(fd[1]), .busy(bsy[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] s1, s2, s3;
        logic       en, fd, busy, err;
    } out_t;

    typedef struct {
        int v, l, c1, c2, c3;
        int e1, e2, e3, een, efd, erdy, ebusy;
    } vec_t;

    int   n_vec;
    int   n_bad;
    int   cyc;
    int   m_beats [2];
    int   m_end   [2];
    logic m_err   [2];
    logic in_rst;
    logic acc_last [2];

    logic [7:0] h1 [2][NCYC];
    logic [7:0] h2 [2][NCYC];
    logic [7:0] h3 [2][NCYC];
    logic       hv [2][NCYC];

    vec_t tbl [11];

    function automatic int max_of(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic out_t act_out(input int d);
        out_t o;
        o.s1 = s1[d]; o.s2 = s2[d]; o.s3 = s3[d];
        o.en = en[d]; o.fd = fd[d]; o.busy = bsy[d]; o.err = er[d];
        return o;
    endfunction

    function automatic out_t exp_out(input int d);
        out_t o;
        o.s1   = h1[d][cyc];
        o.s2   = h2[d][cyc-1];
        o.s3   = h3[d][cyc-2];
        o.en   = hv[d][cyc] | hv[d][cyc-1] | hv[d][cyc-2];
        o.fd   = (cyc == m_end[d] + 2);
        o.busy = (m_beats[d] > 0) || (cyc == m_end[d]) || (cyc == m_end[d] + 1);
        o.err  = m_err[d];
        return o;
    endfunction

    // One clock: drive a beat, check in_ready, clock it, update model, check lanes.
    task automatic step(input int v, input int l, input int c1, input int c2, input int c3);
        logic rdy_m;
        in_valid = (v != 0);
        in_last  = (l != 0);
        col_1 = 8'(c1); col_2 = 8'(c2); col_3 = 8'(c3);
        #1;
        for (int d = 0; d < 2; d++) begin
            rdy_m = !in_rst && !((cyc == m_end[d]) || (cyc == m_end[d] + 1));
            check($sformatf("in_ready[%0d]", d), 32'(rdy[d]), 32'(rdy_m));
            acc_last[d] = in_valid && rdy_m;
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            h1[d][cyc] = acc_last[d] ? col_1 : 8'd0;
            h2[d][cyc] = acc_last[d] ? col_2 : 8'd0;
            h3[d][cyc] = acc_last[d] ? col_3 : 8'd0;
            hv[d][cyc] = acc_last[d];
            if (acc_last[d]) begin
                m_beats[d]++;
                if (in_last || (m_beats[d] == max_of(d))) begin
                    if (!in_last) m_err[d] = 1'b1;
                    m_end[d]   = cyc;
                    m_beats[d] = 0;
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("outputs[%0d]", d), 32'(act_out(d)), 32'(exp_out(d)));
        end
    endtask

    // Asynchronous reset in the middle of a clock phase, checked at once.
    task automatic pulse_reset();
        #3;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_outputs[%0d]", d), 32'(act_out(d)), 32'd0);
            check($sformatf("rst_in_ready[%0d]", d), 32'(rdy[d]), 32'd0);
            m_beats[d] = 0;
            m_end[d]   = -100;
            m_err[d]   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                h1[d][cyc-k] = 8'd0; h2[d][cyc-k] = 8'd0;
                h3[d][cyc-k] = 8'd0; hv[d][cyc-k] = 1'b0;
            end
        end
        in_rst = 1'b1;
        step(1, 0, 1, 2, 3);
        step(1, 1, 4, 5, 6);
        reset  = 1'b1;
        in_rst = 1'b0;
    endtask

    function automatic vec_t mk(input int v, input int l, input int c1, input int c2, input int c3,
                                input int e1, input int e2, input int e3,
                                input int een, input int efd, input int erdy, input int ebusy);
        vec_t t;
        t.v = v; t.l = l; t.c1 = c1; t.c2 = c2; t.c3 = c3;
        t.e1 = e1; t.e2 = e2; t.e3 = e3;
        t.een = een; t.efd = efd; t.erdy = erdy; t.ebusy = ebusy;
        return t;
    endfunction

    initial begin
        int steps;
        int idx;
        logic [31:0] got, want;

        // Back-to-back 8-beat frame: inputs, then lane outputs after that edge.
        tbl[0]  = mk(1, 0,  13,  64, 55,   13,   0,  0, 1, 0, 1, 1);
        tbl[1]  = mk(1, 0,   9, 255,  1,    9,  64,  0, 1, 0, 1, 1);
        tbl[2]  = mk(1, 0,   5,   2,  3,    5, 255, 55, 1, 0, 1, 1);
        tbl[3]  = mk(1, 0, 233, 123, 12,  233,   2,  1, 1, 0, 1, 1);
        tbl[4]  = mk(1, 0,  64,  55, 27,   64, 123,  3, 1, 0, 1, 1);
        tbl[5]  = mk(1, 0, 255,   1, 12,  255,  55, 12, 1, 0, 1, 1);
        tbl[6]  = mk(1, 0,   2,   3,  3,    2,   1, 27, 1, 0, 1, 1);
        tbl[7]  = mk(1, 1, 123,  12,  3,  123,   3, 12, 1, 0, 0, 1);
        tbl[8]  = mk(0, 0,   0,   0,  0,    0,  12,  3, 1, 0, 0, 1);
        tbl[9]  = mk(0, 0,   0,   0,  0,    0,   0,  3, 1, 1, 1, 0);
        tbl[10] = mk(0, 0,   0,   0,  0,    0,   0,  0, 0, 0, 1, 0);

        n_vec = 0; n_bad = 0; cyc = 2; in_rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_beats[d] = 0; m_end[d] = -100; m_err[d] = 1'b0; acc_last[d] = 1'b0;
            for (int k = 0; k < NCYC; k++) begin
                h1[d][k] = 8'd0; h2[d][k] = 8'd0; h3[d][k] = 8'd0; hv[d][k] = 1'b0;
            end
        end

        // Reset state.
        in_valid = 1'b0; in_last = 1'b0; col_1 = 8'd0; col_2 = 8'd0; col_3 = 8'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outputs[%0d]", d), 32'(act_out(d)), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ready_after_reset[%0d]", d), 32'(rdy[d]), 32'd1);
        end

        // Table-driven back-to-back frame on the MAX_BEATS=16 instance.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].c1, tbl[i].c2, tbl[i].c3);
            got  = 32'({s1[0], s2[0], s3[0], en[0], fd[0], rdy[0], bsy[0]});
            want = 32'({8'(tbl[i].e1), 8'(tbl[i].e2), 8'(tbl[i].e3), tbl[i].een[0],
                        tbl[i].efd[0], tbl[i].erdy[0], tbl[i].ebusy[0]});
            check($sformatf("table_row_%0d", i), got, want);
        end

        // Single-column frame, then a new frame offered in the frame_done cycle.
        step(1, 1, 7, 8, 9);
        check("single_lane1", 32'(s1[0]), 32'd7);
        check("single_ready0", 32'(rdy[0]), 32'd0);
        step(0, 0, 0, 0, 0);
        check("single_lane2", 32'(s2[0]), 32'd8);
        check("single_ready1", 32'(rdy[0]), 32'd0);
        step(0, 0, 0, 0, 0);
        check("single_lane3_done", 32'({s3[0], fd[0], rdy[0]}), 32'({8'd9, 1'b1, 1'b1}));
        step(1, 0, 21, 22, 23);
        check("next_frame_lane1", 32'({s1[0], fd[0]}), 32'({8'd21, 1'b0}));
        step(1, 1, 24, 25, 26);
        check("next_frame_lane2", 32'(s2[0]), 32'd22);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // Same 8-beat frame with a one-cycle bubble after beat 3.
        for (int i = 0; i < 8; i++) begin
            step(1, tbl[i].l, tbl[i].c1, tbl[i].c2, tbl[i].c3);
            if (i == 2) begin
                step(0, 0, 0, 0, 0);
                check("bubble_lane1", 32'({s1[0], en[0]}), 32'({8'd0, 1'b1}));
            end
            if (i == 3) check("bubble_lane2", 32'({s2[0], en[0]}), 32'({8'd0, 1'b1}));
            if (i == 4) check("bubble_lane3", 32'({s3[0], en[0]}), 32'({8'd0, 1'b1}));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // Truncation at MAX_BEATS=4: source holds each beat until taken.
        pulse_reset();
        step(0, 0, 0, 0, 0);
        idx = 0;
        steps = 0;
        while ((idx < 6) && (steps < 20)) begin
            step(1, 0, 10 + idx, 20 + idx, 30 + idx);
            steps++;
            if (acc_last[1]) idx++;
            if (idx == 4 && steps == 4) begin
                check("trunc_err", 32'({er[1], rdy[1]}), 32'({1'b1, 1'b0}));
            end
        end
        check("trunc_steps", 32'(steps), 32'd8);
        step(1, 1, 40, 41, 42);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) step(1, 0, 50 + i, 60 + i, 70 + i);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 9) < 7) ? 1 : 0,
                     ($urandom_range(0, 4) == 0) ? 1 : 0,
                     int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
